// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline-side stage information in, stall/flush/forward controls out.
// The pipeline side uses master, the hazard unit uses slave.
interface riscv_hazard_ctrl_if;
  logic [4:0]  i_rs1_d;
  logic [4:0]  i_rs2_d;
  logic [4:0]  i_rs1_e;
  logic [4:0]  i_rs2_e;
  logic [4:0]  i_rd_e;
  logic        i_load_e;
  logic        i_pc_src_e;
  logic [4:0]  i_rd_m;
  logic        i_reg_write_m;
  logic        i_mem_req_m;
  logic        i_dmem_ready;
  logic [4:0]  i_rd_w;
  logic        i_reg_write_w;
  logic        i_cnt_clr;
  logic        o_stall_f;
  logic        o_stall_d;
  logic        o_stall_e;
  logic        o_stall_m;
  logic        o_flush_d;
  logic        o_flush_e;
  logic        o_flush_w;
  logic [1:0]  o_fwd_a_e;
  logic [1:0]  o_fwd_b_e;
  logic        o_state;
  logic        o_mem_timeout;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;

  // Handshake: there is no valid/ready pair. The unit is a per-cycle combinational
  // responder: every i_* field is taken as valid each cycle, and every control output
  // applies to the rising edge of that same cycle.
  modport master (
    output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_load_e, i_pc_src_e,
           i_rd_m, i_reg_write_m, i_mem_req_m, i_dmem_ready, i_rd_w, i_reg_write_w, i_cnt_clr,
    input  o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e, o_flush_w,
           o_fwd_a_e, o_fwd_b_e, o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_load_e, i_pc_src_e,
           i_rd_m, i_reg_write_m, i_mem_req_m, i_dmem_ready, i_rd_w, i_reg_write_w, i_cnt_clr,
    output o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_flush_d, o_flush_e, o_flush_w,
           o_fwd_a_e, o_fwd_b_e, o_state, o_mem_timeout, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Five-stage RISC-V hazard unit: data-memory wait, branch flush, load-use stall,
// operand forwarding, a sticky memory timeout and saturating stall/flush counters.
module riscv_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic               i_clk,
  input logic               i_rstn,
  riscv_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, lu_stall, branch_flush;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign mem_stall    = bus.i_mem_req_m & ~bus.i_dmem_ready;
  assign lu_stall     = bus.i_load_e & (bus.i_rd_e != 5'd0) &
                        ((bus.i_rd_e == bus.i_rs1_d) | (bus.i_rd_e == bus.i_rs2_d));
  assign branch_flush = ~mem_stall & bus.i_pc_src_e;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_stall)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Memory wait wins over everything; a branch redirect wins over a load-use stall
  // because the stalled Decode instruction is on the wrong path anyway.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (bus.i_pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign bus.o_stall_f     = stall_f & i_rstn;
  assign bus.o_stall_d     = stall_d & i_rstn;
  assign bus.o_stall_e     = stall_e & i_rstn;
  assign bus.o_stall_m     = stall_m & i_rstn;
  assign bus.o_flush_d     = flush_d & i_rstn;
  assign bus.o_flush_e     = flush_e & i_rstn;
  assign bus.o_flush_w     = flush_w & i_rstn;
  assign bus.o_fwd_a_e     = i_rstn ? fwd_sel(bus.i_rs1_e, bus.i_rd_m, bus.i_reg_write_m,
                                              bus.i_rd_w, bus.i_reg_write_w) : 2'b00;
  assign bus.o_fwd_b_e     = i_rstn ? fwd_sel(bus.i_rs2_e, bus.i_rd_m, bus.i_reg_write_m,
                                              bus.i_rd_w, bus.i_reg_write_w) : 2'b00;
  assign bus.o_state       = state_q;
  assign bus.o_mem_timeout = timeout_q;
  assign bus.o_stall_cnt   = stall_cnt_q;
  assign bus.o_flush_cnt   = flush_cnt_q;

  always_comb begin
    wait_d      = 16'd0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_stall) begin
      if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
      else                    wait_d = wait_q;
      if (wait_q == TO_LAST) timeout_d = 1'b1;
    end
    if (bus.i_cnt_clr) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end else begin
      if (stall_f && stall_cnt_q != 32'hFFFF_FFFF)      stall_cnt_d = stall_cnt_q + 32'd1;
      if (branch_flush && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_q      <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl: the driver pushes hand-computed expectations
// per cycle, a monitor pops and compares them mid-cycle.
module tb_riscv_hazard_ctrl;
  typedef struct packed {
    logic [3:0]  stall;   // {f,d,e,m}
    logic [2:0]  flush;   // {d,e,w}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } obs_t;
  localparam int W = $bits(obs_t);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  riscv_hazard_ctrl_if bus();

  riscv_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic obs_t mk(input logic [3:0] s, input logic [2:0] f, input logic [1:0] fa,
                              input logic [1:0] fb, input logic st, input logic to,
                              input logic [31:0] sc, input logic [31:0] fc);
    obs_t o;
    o.stall = s; o.flush = f; o.fa = fa; o.fb = fb;
    o.st = st; o.to = to; o.sc = sc; o.fc = fc;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.stall = {bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m};
    o.flush = {bus.o_flush_d, bus.o_flush_e, bus.o_flush_w};
    o.fa = bus.o_fwd_a_e; o.fb = bus.o_fwd_b_e;
    o.st = bus.o_state; o.to = bus.o_mem_timeout;
    o.sc = bus.o_stall_cnt; o.fc = bus.o_flush_cnt;
    return o;
  endfunction

  // driver tasks
  task automatic idle();
    bus.i_rs1_d = 5'd0; bus.i_rs2_d = 5'd0; bus.i_rs1_e = 5'd0; bus.i_rs2_e = 5'd0;
    bus.i_rd_e = 5'd0; bus.i_load_e = 1'b0; bus.i_pc_src_e = 1'b0;
    bus.i_rd_m = 5'd0; bus.i_reg_write_m = 1'b0; bus.i_mem_req_m = 1'b0;
    bus.i_dmem_ready = 1'b1; bus.i_rd_w = 5'd0; bus.i_reg_write_w = 1'b0;
    bus.i_cnt_clr = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic expect_now(input string nm, input obs_t e);
    exp_q.push_back(W'(e));
    name_q.push_back(nm);
  endtask

  task automatic set_mem_wait();
    bus.i_mem_req_m = 1'b1; bus.i_dmem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    bus.i_load_e = 1'b1; bus.i_rd_e = 5'd5; bus.i_rs2_d = 5'd5;
  endtask

  // scoreboard monitor
  always begin
    obs_t e, a;
    string nm;
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e  = obs_t'(exp_q.pop_front());
      nm = name_q.pop_front();
      a  = observe();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b fa=%b fb=%b st=%b to=%b sc=%h fc=%h, want stall=%b flush=%b fa=%b fb=%b st=%b to=%b sc=%h fc=%h",
                 nm, a.stall, a.flush, a.fa, a.fb, a.st, a.to, a.sc, a.fc,
                 e.stall, e.flush, e.fa, e.fb, e.st, e.to, e.sc, e.fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // reset gates every control output even with all hazards presented
    cyc(); rstn = 1'b0; set_mem_wait(); set_load_use(); bus.i_pc_src_e = 1'b1;
    bus.i_rs1_e = 5'd7; bus.i_rd_m = 5'd7; bus.i_reg_write_m = 1'b1;
    expect_now("reset_gate", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    cyc(); rstn = 1'b0; set_load_use(); bus.i_rs2_e = 5'd3; bus.i_rd_w = 5'd3; bus.i_reg_write_w = 1'b1;
    expect_now("reset_gate2", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    cyc(); rstn = 1'b1;
    expect_now("post_reset_idle", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));

    // load-use
    cyc(); set_load_use();
    expect_now("load_use", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0));
    cyc(); bus.i_load_e = 1'b1; bus.i_rd_e = 5'd0;
    expect_now("load_use_x0", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0));

    // forwarding
    cyc(); bus.i_rs1_e = 5'd7; bus.i_rd_m = 5'd7; bus.i_rd_w = 5'd7;
    bus.i_reg_write_m = 1'b1; bus.i_reg_write_w = 1'b1;
    expect_now("fwd_a_mem", mk(4'b0000, 3'b000, 2'b10, 2'b00, 0, 0, 1, 0));
    cyc(); bus.i_rs1_e = 5'd7; bus.i_rd_m = 5'd7; bus.i_rd_w = 5'd7; bus.i_reg_write_w = 1'b1;
    expect_now("fwd_a_wb", mk(4'b0000, 3'b000, 2'b01, 2'b00, 0, 0, 1, 0));
    cyc(); bus.i_rd_m = 5'd0; bus.i_rd_w = 5'd0;
    bus.i_reg_write_m = 1'b1; bus.i_reg_write_w = 1'b1;
    expect_now("fwd_a_x0", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0));
    cyc(); bus.i_rs1_e = 5'd3; bus.i_rs2_e = 5'd9; bus.i_rd_m = 5'd9; bus.i_rd_w = 5'd9;
    bus.i_reg_write_m = 1'b1; bus.i_reg_write_w = 1'b1;
    expect_now("fwd_b_mem", mk(4'b0000, 3'b000, 2'b00, 2'b10, 0, 0, 1, 0));
    cyc(); bus.i_rs1_e = 5'd4; bus.i_rs2_e = 5'd9; bus.i_rd_m = 5'd4; bus.i_rd_w = 5'd9;
    bus.i_reg_write_m = 1'b1; bus.i_reg_write_w = 1'b1;
    expect_now("fwd_a_mem_b_wb", mk(4'b0000, 3'b000, 2'b10, 2'b01, 0, 0, 1, 0));

    // branch beats load-use
    cyc(); bus.i_pc_src_e = 1'b1; bus.i_load_e = 1'b1; bus.i_rd_e = 5'd5; bus.i_rs1_d = 5'd5;
    expect_now("branch_over_lu", mk(4'b0000, 3'b110, 2'b00, 2'b00, 0, 0, 1, 0));

    // memory wait with a pending branch
    for (int i = 0; i < 3; i++) begin
      cyc(); set_mem_wait(); bus.i_pc_src_e = 1'b1;
      expect_now($sformatf("mem_wait_%0d", i),
                 mk(4'b1111, 3'b001, 2'b00, 2'b00, (i > 0), 0, 32'(1 + i), 1));
    end
    cyc(); bus.i_mem_req_m = 1'b1; bus.i_pc_src_e = 1'b1;
    expect_now("mem_ready_branch", mk(4'b0000, 3'b110, 2'b00, 2'b00, 1, 0, 4, 1));
    cyc();
    expect_now("back_to_run", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 4, 2));

    // timeout after the 4th stalled edge, sticky past ready
    for (int i = 0; i < 4; i++) begin
      cyc(); set_mem_wait();
      expect_now($sformatf("to_wait_%0d", i),
                 mk(4'b1111, 3'b001, 2'b00, 2'b00, (i > 0), 0, 32'(4 + i), 2));
    end
    cyc(); bus.i_mem_req_m = 1'b1;
    expect_now("timeout_set", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1, 1, 8, 2));
    cyc();
    expect_now("timeout_sticky", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 1, 8, 2));
    cyc(); rstn = 1'b0;
    expect_now("reset_clears_to", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    cyc(); rstn = 1'b1;
    expect_now("after_reset", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));

    // reset in the middle of a wait leaves a clean wait count
    for (int i = 0; i < 3; i++) begin
      cyc(); set_mem_wait();
      expect_now($sformatf("pre_rst_wait_%0d", i),
                 mk(4'b1111, 3'b001, 2'b00, 2'b00, (i > 0), 0, 32'(i), 0));
    end
    cyc(); rstn = 1'b0; set_mem_wait();
    expect_now("rst_mid_wait", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));
    cyc(); rstn = 1'b1; set_mem_wait();
    expect_now("wait_after_rst", mk(4'b1111, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0));
    cyc();
    expect_now("no_stale_timeout", mk(4'b0000, 3'b000, 2'b00, 2'b00, 1, 0, 1, 0));
    cyc();
    expect_now("run_again", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0));

    // counter saturation and clear priority
    @(negedge clk);
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    set_load_use();
    expect_now("sat_preload", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF, 0));
    #1 release dut.stall_cnt_q;
    cyc(); set_load_use();
    expect_now("sat_hold", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF, 0));
    cyc(); set_load_use(); bus.i_cnt_clr = 1'b1;
    expect_now("clr_with_stall", mk(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF, 0));
    cyc();
    expect_now("after_clr", mk(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0));

    cyc();
    cyc();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_hazard_ctrl.md
RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: consecutive data-memory wait cycles before the timeout flag is raised (range 1..65535).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports i_rs1_d / i_rs2_d, input, 5 bits each: source register addresses of the instruction in Decode.
REQ-005 SHALL have ports i_rs1_e / i_rs2_e / i_rd_e, input, 5 bits each: source and destination register addresses in Execute.
REQ-006 SHALL have port i_load_e, input, 1 bit: the Execute instruction is a load (result source = memory).
REQ-007 SHALL have port i_pc_src_e, input, 1 bit: a taken branch or jump in Execute.
REQ-008 SHALL have ports i_rd_m (5 bits) and i_reg_write_m (1 bit), input: Memory-stage destination and its write enable.
REQ-009 SHALL have ports i_mem_req_m and i_dmem_ready, input, 1 bit each: data-memory request from Memory and its ready response.
REQ-010 SHALL have ports i_rd_w (5 bits) and i_reg_write_w (1 bit), input: Writeback-stage destination and its write enable.
REQ-011 SHALL have port i_cnt_clr, input, 1 bit: synchronous clear of the performance counters.
REQ-012 SHALL have ports o_stall_f / o_stall_d / o_stall_e / o_stall_m, output, 1 bit each: hold the pipeline register feeding each stage.
REQ-013 SHALL have ports o_flush_d / o_flush_e / o_flush_w, output, 1 bit each: load a bubble into that stage's register.
REQ-014 SHALL have ports o_fwd_a_e / o_fwd_b_e, output, 2 bits each: operand select, 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-015 SHALL have port o_state, output, 1 bit: FSM state, 0 = RUN, 1 = MEM_WAIT.
REQ-016 SHALL have port o_mem_timeout, output, 1 bit: sticky data-memory timeout flag.
REQ-017 SHALL have ports o_stall_cnt / o_flush_cnt, output, 32 bits each: performance counters.

Function
REQ-018 SHALL define mem_stall = i_mem_req_m & ~i_dmem_ready, computed combinationally in either FSM state.
REQ-019 SHALL define lu_stall = i_load_e & (i_rd_e != 0) & (i_rd_e == i_rs1_d | i_rd_e == i_rs2_d).
REQ-020 SHALL, while mem_stall = 1: assert all four o_stall_* and o_flush_w, and hold o_flush_d = o_flush_e = 0; load-use and branch actions are deferred.
REQ-021 SHALL, while mem_stall = 0 and i_pc_src_e = 1: assert o_flush_d and o_flush_e, with all stalls 0; the branch flush takes precedence over lu_stall.
REQ-022 SHALL, while mem_stall = 0, i_pc_src_e = 0 and lu_stall = 1: assert o_stall_f, o_stall_d and o_flush_e, in the same cycle as detection.
REQ-023 SHALL set o_fwd_a_e to 10 if i_reg_write_m & i_rd_m != 0 & i_rd_m == i_rs1_e; otherwise to 01 if the same test holds on the W stage; otherwise to 00. The Memory stage has priority.
REQ-024 SHALL compute o_fwd_b_e identically to REQ-023, using i_rs2_e.
REQ-025 SHALL move the FSM from RUN to MEM_WAIT on an edge where mem_stall = 1, and from MEM_WAIT to RUN on an edge where mem_stall = 0; there are no other transitions.
REQ-026 SHALL keep a 16-bit wait counter: 0 whenever mem_stall = 0, and incremented (saturating) on each edge where mem_stall = 1.
REQ-027 SHALL set o_mem_timeout on the edge where mem_stall = 1 and the wait counter equals MEM_TIMEOUT-1; the flag stays set until reset, and the pipeline remains stalled.
REQ-028 SHALL increment o_stall_cnt on each edge where o_stall_f = 1, and o_flush_cnt on each edge where i_pc_src_e-caused flushing is active (REQ-021); both saturate at 0xFFFFFFFF.
REQ-029 SHALL give i_cnt_clr priority over increment: the counters read 0 after the clearing edge.

Reset
REQ-030 SHALL, while i_rstn = 0, force o_state = RUN, the wait counter = 0, o_mem_timeout = 0 and both counters = 0, asynchronously.
REQ-031 SHALL, while i_rstn = 0, gate every o_stall_*, o_flush_* and o_fwd_* output to 0 regardless of inputs.
REQ-032 SHALL, when reset is asserted mid-MEM_WAIT, abandon the wait; after release the FSM is in RUN with a clean wait count.

Verification
REQ-033 SHALL cover load-use: i_load_e=1, i_rd_e=5, i_rs2_d=5 -> o_stall_f=o_stall_d=o_flush_e=1 for one cycle and o_stall_cnt +1; repeating with i_rd_e=0 -> no stall.
REQ-034 SHALL cover forwarding: i_rs1_e=7, i_rd_m=7, i_rd_w=7, both write enables 1 -> o_fwd_a_e=10; i_reg_write_m=0 -> 01; i_rs1_e=0 -> 00.
REQ-035 SHALL cover branch: i_pc_src_e=1 together with lu_stall=1 -> o_flush_d=o_flush_e=1, o_stall_f=0, o_flush_cnt +1.
REQ-036 SHALL cover memory wait: i_mem_req_m=1, i_dmem_ready=0 for 3 cycles with i_pc_src_e=1 -> all stalls and o_flush_w=1 and o_flush_d=0 for 3 cycles, o_state=1 from the 2nd cycle; on ready=1 -> o_flush_d/e=1 and o_state returns to 0.
REQ-037 SHALL cover timeout with MEM_TIMEOUT=4: ready held 0 -> o_mem_timeout rises after the 4th stalled edge and stays 1 after ready=1; a reset pulse then clears it and the counters.
REQ-038 SHALL cover counter saturation and clear: force o_stall_cnt=0xFFFFFFFF -> holds under further stalls; i_cnt_clr=1 together with a stall -> reads 0.
